// File: rtl/mbox_arb_pkg.sv
// rtl/mbox_arb_pkg.sv - shared types and defaults for the MBOX cycle arbiter
package mbox_arb_pkg;

  typedef enum logic [1:0] {
    CHAN  = 2'd0,
    EBOX  = 2'd1,
    SWEEP = 2'd2,
    NONE  = 2'd3
  } reqId_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } arbState_t;

  localparam int TIMEOUT_DEF    = 64;
  localparam int STARVE_MAX_DEF = 4;

  function automatic logic [2:0] id_onehot(input reqId_t id);
    logic [2:0] oh;
    oh = 3'b000;
    case (id)
      CHAN:    oh = 3'b001;
      EBOX:    oh = 3'b010;
      SWEEP:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mbox_cycle_arb_if.sv
// rtl/mbox_cycle_arb_if.sv - requester and memory-port signals of the MBOX cycle arbiter
interface mbox_cycle_arb_if #(
  parameter int ADDR_W = 22
);
  logic [2:0]             req;
  logic [2:0]             reqWrite;
  logic [2:0][ADDR_W-1:0] reqAddr;
  logic [2:0]             grant;
  logic [2:0]             done;
  logic [2:0]             err;
  logic                   memReq;
  logic                   memWrite;
  logic [ADDR_W-1:0]      memAddr;
  logic                   memAck;
  logic                   nxm;
  logic                   nxmClr;
  logic                   busy;
  logic [1:0]             owner;

  modport master (
    output req, reqWrite, reqAddr, memAck, nxmClr,
    input  grant, done, err, memReq, memWrite, memAddr, nxm, busy, owner
  );

  modport slave (
    input  req, reqWrite, reqAddr, memAck, nxmClr,
    output grant, done, err, memReq, memWrite, memAddr, nxm, busy, owner
  );
endinterface

// File: rtl/mbox_arb_pick.sv
// rtl/mbox_arb_pick.sv - winner selection with EBOX anti-starvation counter
module mbox_arb_pick
  import mbox_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arb,
  input  logic [2:0] i_req,
  output reqId_t     o_winner
);

  localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

  logic [3:0] r_starve;
  reqId_t     w_winner;

  always_comb begin
    w_winner = NONE;
    if (i_req[1] && (r_starve == STARVE_CAP)) w_winner = EBOX;
    else if (i_req[0])                        w_winner = CHAN;
    else if (i_req[1])                        w_winner = EBOX;
    else if (i_req[2])                        w_winner = SWEEP;
  end

  // Counts channel wins that EBOX had to watch; only meaningful while EBOX waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (i_arb) begin
      if (!i_req[1] || (w_winner == EBOX)) begin
        r_starve <= '0;
      end else if ((w_winner == CHAN) && (r_starve != STARVE_CAP)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  assign o_winner = w_winner;

endmodule

// File: rtl/mbox_cycle_arb.sv
// rtl/mbox_cycle_arb.sv - MBOX memory-cycle sequencer sharing the core-memory port
// among channel, EBOX and cache sweep, with NXM timeout.
module mbox_cycle_arb
  import mbox_arb_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             mboxClk,
  input  logic             CROBAR_n,
  mbox_cycle_arb_if.slave  bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arbState_t         r_state;
  arbState_t         w_next;
  logic [7:0]        r_tcnt;
  reqId_t            r_owner;
  logic [2:0]        r_grant;
  logic              r_timed_out;
  logic              r_nxm;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;

  reqId_t            w_winner;
  logic              w_start;
  logic              w_tmo_hit;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;

  mbox_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (mboxClk),
    .rst_n    (CROBAR_n),
    .i_arb    (r_state == IDLE),
    .i_req    (bus.req),
    .o_winner (w_winner)
  );

  assign w_start   = (r_state == IDLE) && (|bus.req);
  assign w_tmo_hit = (r_state == REQ) && !bus.memAck && (r_tcnt == TMO_LAST);

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    case (w_winner)
      CHAN:  begin w_sel_write = bus.reqWrite[0]; w_sel_addr = bus.reqAddr[0]; end
      EBOX:  begin w_sel_write = bus.reqWrite[1]; w_sel_addr = bus.reqAddr[1]; end
      SWEEP: begin w_sel_write = bus.reqWrite[2]; w_sel_addr = bus.reqAddr[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge mboxClk or negedge CROBAR_n) begin
    if (!CROBAR_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|bus.req) w_next = REQ;
      REQ:     if (bus.memAck || (r_tcnt == TMO_LAST)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge mboxClk or negedge CROBAR_n) begin
    if (!CROBAR_n) begin
      r_tcnt      <= '0;
      r_owner     <= NONE;
      r_grant     <= '0;
      r_timed_out <= 1'b0;
      r_nxm       <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_grant <= '0;
      if (w_start) begin
        r_owner     <= w_winner;
        r_grant     <= id_onehot(w_winner);
        r_mem_write <= w_sel_write;
        r_mem_addr  <= w_sel_addr;
        r_tcnt      <= '0;
        r_timed_out <= 1'b0;
      end else if (r_state == REQ) begin
        r_tcnt <= r_tcnt + 8'd1;
        if (w_tmo_hit) r_timed_out <= 1'b1;
      end else if (r_state == DONE) begin
        r_owner <= NONE;
      end
      // A fresh timeout outranks a simultaneous clear.
      if (w_tmo_hit)       r_nxm <= 1'b1;
      else if (bus.nxmClr) r_nxm <= 1'b0;
    end
  end

  always_comb begin
    bus.memReq   = (r_state == REQ);
    bus.busy     = (r_state != IDLE);
    bus.grant    = r_grant;
    bus.done     = (r_state == DONE) ? id_onehot(r_owner) : 3'b000;
    bus.err      = ((r_state == DONE) && r_timed_out) ? id_onehot(r_owner) : 3'b000;
    bus.owner    = r_owner;
    bus.memWrite = r_mem_write;
    bus.memAddr  = r_mem_addr;
    bus.nxm      = r_nxm;
  end

endmodule
